// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions: board size defaults, the line-clear FSM
// state encoding and a row-occupancy helper.
package tetris_pkg;

  localparam int BOARD_COLS = 7;
  localparam int BOARD_ROWS = 7;

  // Widest grid and row the row_full helper can inspect.
  localparam int GRID_MAX_BITS = 1024;
  localparam int MAX_COLS      = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // True when every cell of row r is occupied. The caller zero-extends the grid
  // to GRID_MAX_BITS. Each row is cols cells wide.
  function automatic logic row_full(input logic [GRID_MAX_BITS-1:0] grid,
                                    input int r, input int cols);
    logic full;
    full = 1'b1;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (c < cols) full &= grid[r*cols + c];
    end
    return full;
  endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Request/result bundle between the lock logic (master) and the line-clear
// engine (slave).
interface line_clear_engine_if #(
  parameter int COLS = tetris_pkg::BOARD_COLS,
  parameter int ROWS = tetris_pkg::BOARD_ROWS
);
  localparam int CW = $clog2(ROWS + 1);

  logic                 start;
  logic [ROWS*COLS-1:0] grid_in;
  logic                 busy;
  logic                 done;
  logic [ROWS*COLS-1:0] grid_out;
  logic [CW-1:0]        lines_cleared;
  logic [ROWS-1:0]      full_mask;

  modport master (output start, grid_in,
                  input  busy, done, grid_out, lines_cleared, full_mask);
  modport slave  (input  start, grid_in,
                  output busy, done, grid_out, lines_cleared, full_mask);
endinterface

// File: rtl/line_clear_engine_row_remove.sv
// Combinational row removal: drops row idx, shifts every row above it down by
// one, and inserts an empty row at the top. Rows below idx are untouched.
module row_remove #(
  parameter int COLS = tetris_pkg::BOARD_COLS,
  parameter int ROWS = tetris_pkg::BOARD_ROWS,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS*COLS-1:0] grid,
  input  logic [RW-1:0]        idx,
  output logic [ROWS*COLS-1:0] grid_out
);

  always_comb begin
    // NOTE: assign a full default before the loop so no bit is left unassigned and no latch is inferred.
    grid_out = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(idx)) grid_out[r*COLS +: COLS] = grid[(r-1)*COLS +: COLS];
      else                grid_out[r*COLS +: COLS] = grid[r*COLS +: COLS];
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// Multi-cycle line-clear engine: snapshots the playfield on start, then
// removes one full row per cycle scanning from the bottom row upward.
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS
) (
  input logic            clk,
  input logic            rst_n,
  line_clear_engine_if.slave bus
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] grid_q, grid_d, grid_removed;
  logic [CW-1:0]        lc_q, lc_d;
  logic [ROWS-1:0]      mask_q, mask_d, in_mask;
  logic [RW-1:0]        idx_q, idx_d;
  logic                 cur_full;

  row_remove #(.COLS(COLS), .ROWS(ROWS), .RW(RW)) u_row_remove (
    .grid     (grid_q),
    .idx      (idx_q),
    .grid_out (grid_removed)
  );

  always_comb begin
    in_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      in_mask[r] = row_full(GRID_MAX_BITS'(bus.grid_in), r, COLS);
    end
    cur_full = row_full(GRID_MAX_BITS'(grid_q), int'(idx_q), COLS);
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    lc_d    = lc_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          grid_d  = bus.grid_in;
          mask_d  = in_mask;
          lc_d    = '0;
          idx_d   = RW'(ROWS - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        // A full row is removed without moving idx, so the row that drops into it is checked next cycle.
        if (cur_full) begin
          grid_d = grid_removed;
          lc_d   = lc_q + CW'(1);
        end else if (idx_q != '0) begin
          idx_d = idx_q - RW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grid_q  <= '0;
      lc_q    <= '0;
      mask_q  <= '0;
      idx_q   <= RW'(ROWS - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      grid_q  <= grid_d;
      lc_q    <= lc_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.grid_out      = grid_q;
  assign bus.lines_cleared = lc_q;
  assign bus.full_mask     = mask_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: a 7x7 instance and a 10x20 instance,
// with hand-computed results, latencies and busy/done timing.
module tb_line_clear_engine;

  logic clk;
  logic rst_n;

  line_clear_engine_if #(.COLS(7),  .ROWS(7))  s_if ();
  line_clear_engine_if #(.COLS(10), .ROWS(20)) b_if ();

  line_clear_engine #(.COLS(7), .ROWS(7)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  line_clear_engine #(.COLS(10), .ROWS(20)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on the 7x7 instance. With repulse set, start is pulsed again
  // mid-scan with grid g2, which must be ignored.
  task automatic run_small(input logic [48:0] g, input bit repulse, input logic [48:0] g2,
                           output int edges, output int busy_cycles);
    bit seen;
    @(negedge clk);
    s_if.grid_in = g;
    s_if.start   = 1'b1;
    @(posedge clk); #1;
    busy_cycles = int'(s_if.busy);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (repulse && edges == 2) begin
        s_if.start   = 1'b1;
        s_if.grid_in = g2;
      end else begin
        s_if.start   = 1'b0;
        s_if.grid_in = ~g;
      end
      @(posedge clk); #1;
      edges++;
      busy_cycles += int'(s_if.busy);
      if (s_if.done) seen = 1'b1;
    end
    if (!seen) check("small_timeout", 256'(seen), 256'(1));
    @(negedge clk);
    s_if.start = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", 256'(s_if.done), 256'(0));
    check("busy_after_done", 256'(s_if.busy), 256'(0));
  endtask

  logic [48:0]  g_empty, g_two, g_three, g_full, e_two, e_three;
  logic [199:0] bg, be;
  int edges, busy_cycles, done_cnt;
  bit seen;

  initial begin
    rst_n        = 1'b0;
    s_if.start   = 1'b0;
    s_if.grid_in = '0;
    b_if.start   = 1'b0;
    b_if.grid_in = '0;

    g_empty = '0;
    g_full  = {49{1'b1}};
    g_two = '0;  g_two[6*7 +: 7] = 7'h7F;  g_two[5*7 +: 7] = 7'h01;
    e_two = '0;  e_two[6*7 +: 7] = 7'h01;
    g_three = '0;
    g_three[6*7 +: 7] = 7'h7F; g_three[5*7 +: 7] = 7'h7F; g_three[3*7 +: 7] = 7'h7F;
    g_three[4*7 +: 7] = 7'h2A; g_three[2*7 +: 7] = 7'h11;
    e_three = '0; e_three[6*7 +: 7] = 7'h2A; e_three[5*7 +: 7] = 7'h11;

    #12;
    check("rst_grid", 256'(s_if.grid_out), 256'(0));
    check("rst_lc", 256'(s_if.lines_cleared), 256'(0));
    check("rst_mask", 256'(s_if.full_mask), 256'(0));
    check("rst_busy", 256'(s_if.busy), 256'(0));
    check("rst_done", 256'(s_if.done), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Empty grid
    run_small(g_empty, 1'b0, '0, edges, busy_cycles);
    check("empty_edges", 256'(edges), 256'(7));
    check("empty_busy", 256'(busy_cycles), 256'(8));
    check("empty_grid", 256'(s_if.grid_out), 256'(0));
    check("empty_lc", 256'(s_if.lines_cleared), 256'(0));
    check("empty_mask", 256'(s_if.full_mask), 256'(0));

    // Bottom row full, row 5 drops into it
    run_small(g_two, 1'b0, '0, edges, busy_cycles);
    check("one_edges", 256'(edges), 256'(8));
    check("one_grid", 256'(s_if.grid_out), 256'(e_two));
    check("one_lc", 256'(s_if.lines_cleared), 256'(1));
    check("one_mask", 256'(s_if.full_mask), 256'(7'b1000000));

    // Three non-adjacent full rows
    run_small(g_three, 1'b0, '0, edges, busy_cycles);
    check("three_edges", 256'(edges), 256'(10));
    check("three_grid", 256'(s_if.grid_out), 256'(e_three));
    check("three_lc", 256'(s_if.lines_cleared), 256'(3));
    check("three_mask", 256'(s_if.full_mask), 256'(7'b1101000));

    // Entire board full: worst-case latency
    run_small(g_full, 1'b0, '0, edges, busy_cycles);
    check("full_edges", 256'(edges), 256'(14));
    check("full_busy", 256'(busy_cycles), 256'(15));
    check("full_grid", 256'(s_if.grid_out), 256'(0));
    check("full_lc", 256'(s_if.lines_cleared), 256'(7));
    check("full_mask", 256'(s_if.full_mask), 256'(7'h7F));

    // start re-pulsed during SCAN is ignored, then a later start runs normally
    run_small(g_two, 1'b1, g_full, edges, busy_cycles);
    check("repulse_edges", 256'(edges), 256'(8));
    check("repulse_grid", 256'(s_if.grid_out), 256'(e_two));
    check("repulse_lc", 256'(s_if.lines_cleared), 256'(1));
    run_small(g_full, 1'b0, '0, edges, busy_cycles);
    check("second_edges", 256'(edges), 256'(14));
    check("second_lc", 256'(s_if.lines_cleared), 256'(7));

    // Reset mid-scan aborts asynchronously with no done
    @(negedge clk);
    s_if.grid_in = g_full;
    s_if.start   = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 256'(s_if.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("abort_grid", 256'(s_if.grid_out), 256'(0));
    check("abort_lc", 256'(s_if.lines_cleared), 256'(0));
    check("abort_mask", 256'(s_if.full_mask), 256'(0));
    check("abort_busy", 256'(s_if.busy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      done_cnt += int'(s_if.done);
    end
    check("abort_no_done", 256'(done_cnt), 256'(0));
    run_small(g_three, 1'b0, '0, edges, busy_cycles);
    check("post_abort_edges", 256'(edges), 256'(10));
    check("post_abort_grid", 256'(s_if.grid_out), 256'(e_three));
    check("post_abort_lc", 256'(s_if.lines_cleared), 256'(3));

    // 10x20 instance: two full bottom rows, row 17 drops to the bottom
    bg = '0; bg[19*10 +: 10] = 10'h3FF; bg[18*10 +: 10] = 10'h3FF; bg[17*10 +: 10] = 10'h3FE;
    be = '0; be[19*10 +: 10] = 10'h3FE;
    @(negedge clk);
    b_if.grid_in = bg;
    b_if.start   = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    b_if.start   = 1'b0;
    b_if.grid_in = '0;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (b_if.done) seen = 1'b1;
    end
    if (!seen) check("big_timeout", 256'(seen), 256'(1));
    check("big_edges", 256'(edges), 256'(22));
    check("big_grid", 256'(b_if.grid_out), 256'(be));
    check("big_lc", 256'(b_if.lines_cleared), 256'(2));
    check("big_mask", 256'(b_if.full_mask), 256'(20'hC0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
Multi-cycle, parametrised line-clear unit for the Tetris playfield. It takes a snapshot of the fallen-pieces grid and removes every full row, one row per cycle. Rows above each cleared row move down, and rows enter empty at the top. It reports the cleaned grid, the number of lines cleared and a mask of the rows that were full. It sits between the lock/landing logic and the score/spawn logic, and it replaces the single-row combinational shifter.

Parameters:
COLS, 7, cells per row; row r occupies bits [r*COLS +: COLS].
ROWS, 7, number of rows; row 0 is the top of the board, row ROWS-1 is the bottom.
CW, $clog2(ROWS+1), width of lines_cleared (localparam).
RW, $clog2(ROWS), width of the row index (localparam).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
grid_in  in  ROWS*COLS  fallen-pieces grid; sampled on the accepted start edge.
busy  out  1  high in SCAN and DONE.
done  out  1  one-cycle pulse; grid_out, lines_cleared and full_mask are valid from this cycle on.
grid_out  out  ROWS*COLS  working/result grid; holds its value until the next accepted start.
lines_cleared  out  CW  number of rows removed in this operation, 0..ROWS.
full_mask  out  ROWS  bit r set if row r of grid_in was full at start (for the flash animation).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grid_out=0; lines_cleared=0; full_mask=0; row index=ROWS-1; busy=0; done=0. A reset mid-operation aborts immediately, and no done is issued.
- IDLE, start=1 at an edge:
  - grid_out <= grid_in; full_mask <= per-row AND-reduce of grid_in; lines_cleared <= 0; idx <= ROWS-1; state <= SCAN.
- SCAN, one step per edge, acting on row idx of grid_out:
  - Row idx full: rows 0..idx-1 move to rows 1..idx; row 0 <= 0; rows idx+1..ROWS-1 are unchanged; lines_cleared += 1; idx is unchanged, so the new content of that row is re-checked.
  - Row idx not full, idx>0: idx <= idx-1.
  - Row idx not full, idx==0: state <= DONE.
  - Row 0 after a shift is all zero, so it can never be full when COLS>=1, and the scan always terminates.
- DONE: done=1 for exactly this cycle; state <= IDLE on the next edge.
- Latency: the number of edges from the accepted start edge to the done-high cycle is ROWS + k, where k = lines_cleared.
  - Worst case (full grid) is 2*ROWS.
- start while busy is ignored, with no queuing.
- start held high: a new operation is accepted on the first IDLE edge after DONE.
- grid_in changes after acceptance have no effect.
- lines_cleared never exceeds ROWS, and CW is sized to hold it.
- done and busy are registered state decodes, with no combinational path from start or grid_in.

Decomposition:
- Shared package tetris_pkg:
  - BOARD_COLS=7 and BOARD_ROWS=7, used as parameter defaults.
  - State enum {IDLE, SCAN, DONE}.
  - Function row_full(grid, r).
- Sub-module row_remove: purely combinational, parameters COLS/ROWS.
  - Inputs grid and idx; output is the grid with row idx removed, rows above shifted down and a zero top row.
  - This is the generalised successor of the old fixed 7x7 shifter; the engine instantiates it once.

Test Plan:
- Empty grid (all 0), start pulse -> done high 7 edges after start; grid_out=0; lines_cleared=0; full_mask=0; busy high for exactly 8 cycles.
- Row 6 = 7'h7F, row 5 = 7'h01, others 0 -> done after 8 edges; new row 6 = 7'h01, rows 0..5 = 0; lines_cleared=1; full_mask=7'b1000000.
- Rows 6, 5 and 3 full, row 4 = 7'h2A, row 2 = 7'h11 -> done after 10 edges; row 6 = 7'h2A, row 5 = 7'h11, rows 0..4 = 0; lines_cleared=3; full_mask=7'b1101000.
- Every row = 7'h7F -> done after 14 edges; grid_out=0; lines_cleared=7.
- start re-pulsed in SCAN with a different grid_in -> ignored; result matches the first grid; the second start, issued after done, runs normally.
- rst_n driven low for 1 cycle during SCAN -> all outputs 0 asynchronously, no done pulse; the next start runs a full operation.
- COLS=10, ROWS=20 instance, with rows 19 and 18 full and row 17 = 10'h3FE -> done after 22 edges; row 19 = 10'h3FE; lines_cleared=2.
